// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between the control FSM and mult_div_unit.
// The control side uses the master modport; the unit itself uses slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply / restoring divide, one bit per cycle, on operand
// magnitudes with sign correction applied when the result is written to hi/lo.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     mcand_r;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_r;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic                 neg_r;       // product / quotient is negative
  logic                 neg_rem_r;   // remainder takes the dividend's sign
  logic                 dz_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 div_zero_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH-1:0]     rem_sh_s;
  logic [WIDTH:0]       diff_s;
  logic [2*WIDTH-1:0]   acc_nxt_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (-v) : v;
  endfunction

  // One shift-add or restoring-subtract step on the shared accumulator
  always_comb begin
    acc_nxt_s = acc_r;
    sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    rem_sh_s  = {acc_r[2*WIDTH-2:WIDTH], acc_r[WIDTH-1]};
    diff_s    = {1'b0, rem_sh_s} - {1'b0, mcand_r};
    case (state_r)
      MULT: acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
      DIV: begin
        if (!diff_s[WIDTH]) begin
          acc_nxt_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_nxt_s = {rem_sh_s, acc_r[WIDTH-2:0], 1'b0};
        end
      end
      default: acc_nxt_s = acc_r;
    endcase
  end

  // Sign-corrected results taken from the final step's accumulator
  always_comb begin
    prod_s = neg_r ? (-acc_nxt_s) : acc_nxt_s;
    quo_s  = neg_r ? (-acc_nxt_s[WIDTH-1:0]) : acc_nxt_s[WIDTH-1:0];
    rem_s  = neg_rem_r ? (-acc_nxt_s[2*WIDTH-1:WIDTH]) : acc_nxt_s[2*WIDTH-1:WIDTH];
  end

  // Control FSM, datapath registers and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      mcand_r    <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      neg_r      <= 1'b0;
      neg_rem_r  <= 1'b0;
      dz_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      busy_r     <= (state_r == MULT) || (state_r == DIV);
      done_r     <= (state_r == DONE);
      div_zero_r <= (state_r == DONE) && dz_r;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r     <= {CW{1'b0}};
            neg_r     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_rem_r <= bus.a[WIDTH-1];
            if (!bus.op) begin
              mcand_r <= mag(bus.a);
              acc_r   <= {{WIDTH{1'b0}}, mag(bus.b)};
              dz_r    <= 1'b0;
              state_r <= MULT;
            end else if (bus.b == {WIDTH{1'b0}}) begin
              dz_r    <= 1'b1;
              state_r <= DONE;
            end else begin
              mcand_r <= mag(bus.b);
              acc_r   <= {{WIDTH{1'b0}}, mag(bus.a)};
              dz_r    <= 1'b0;
              state_r <= DIV;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MULT, DIV: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= DONE;
            if (state_r == MULT) begin
              hi_r <= prod_s[2*WIDTH-1:WIDTH];
              lo_r <= prod_s[WIDTH-1:0];
            end else begin
              hi_r <= rem_s;
              lo_r <= quo_s;
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          dz_r    <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit that produces the Hi and Lo registers consumed by the datapath's result-select mux. It runs a multicycle shift-add multiply or restoring divide on two operands, one bit per cycle. It holds the results in internal Hi/Lo registers until the next completed operation. The control FSM launches an operation with a one-cycle `start` pulse and waits on `done`.

## Interface

Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous active-high reset.
- start  input  1  launch pulse; sampled only in IDLE.
- op  input  1  0 = signed multiply, 1 = signed divide.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high while in MULT or DIV.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  high together with done when a divide had b == 0.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.

## Operation

- FSM states: IDLE, MULT, DIV, DONE.
- IDLE:
  - start=1, op=0: latch the operand magnitudes and the result sign, clear the iteration counter, go to MULT.
  - start=1, op=1, b≠0: latch magnitudes and signs, go to DIV.
  - start=1, op=1, b==0: go directly to DONE with div_zero set. hi/lo are not written.
- MULT: shift-add on magnitudes, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- DIV: restoring division on magnitudes, one quotient bit per cycle.
- Leaving MULT/DIV: after WIDTH iterations, the FSM goes to DONE. On that same edge, hi/lo are written with sign-corrected results.
- Multiply result: {hi,lo} = full 2·WIDTH-bit signed product.
- Divide result:
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Overflow case a = 0x80000000, b = 0xFFFFFFFF: lo = 0x80000000, hi = 0. No flag is raised.
- DONE: lasts one cycle, then the FSM returns to IDLE unconditionally.
  - done = (state == DONE).
  - div_zero is high only in a DONE state reached through the divide-by-zero path.
- start while not in IDLE (including DONE): ignored. a, b, op are don't-care outside the start cycle.
- hi/lo keep their values across IDLE and across divide-by-zero. They change only on the transition MULT/DIV→DONE.
- Internal operand registers are not visible; partial results never appear on hi/lo.

## Timing

- Reset:
  - state = IDLE; hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, counter = 0.
  - Reset mid-operation aborts immediately. No done pulse follows.
- Let edge E be the one that samples start=1 in IDLE.
- Normal latency:
  - busy is high for cycles E+1 … E+WIDTH, i.e. 32 cycles.
  - done is high for the single cycle after edge E+WIDTH+1, i.e. 33 edges after E.
  - hi/lo are valid from that same cycle onward.
- Divide by zero: done and div_zero are high in the cycle after edge E+1. busy never asserts.
- The earliest next start is accepted in the first IDLE cycle after DONE (back-to-back throughput of WIDTH+2 cycles).
- Reset has priority over start when both are high on the same edge.

## Test plan

- Multiply: mult a=7, b=0xFFFFFFFD (−3) -> done exactly 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 32 cycles.
- Multiply, largest negative: mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Signed divide: div a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Also a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- Divide by zero: after the previous op leaves hi=0x12345678, lo=0x9ABCDEF0, div with b=0 -> done and div_zero high one cycle after the start edge; busy stays 0; hi/lo unchanged.
- Divide overflow: div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Control and reset:
  - Pulse start again at cycle 5 of a multiply -> ignored; the result matches the first operands.
  - Assert reset at busy cycle 10 -> next cycle all outputs 0, state IDLE, no done pulse.
  - A fresh mult 3×4 then completes with lo=12, hi=0.
